// File: rtl/fifo_ctrl_pkg.sv
// Shared types for the single-port FIFO access scheduler: controller states
// and the per-cycle grant encoding.
package fifo_ctrl_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    typedef logic [1:0] gnt_t;

    localparam gnt_t GNT_NONE = 2'd0;
    localparam gnt_t GNT_RD   = 2'd1;
    localparam gnt_t GNT_WR0  = 2'd2;
    localparam gnt_t GNT_WR1  = 2'd3;

endpackage

// File: rtl/fifo_wr_rr_arb.sv
// Two-way round-robin arbiter between the write requesters: the pointed-to
// requester wins if eligible, otherwise the other one; the winner loses priority.
module fifo_wr_rr_arb (
    input  logic [1:0] elig_i,
    input  logic       rr_ptr_i,
    output logic [1:0] win_o,
    output logic       next_ptr_o
);

    logic other;
    assign other = ~rr_ptr_i;

    always_comb begin
        win_o      = 2'b00;
        next_ptr_o = rr_ptr_i;
        if (elig_i[rr_ptr_i]) begin
            win_o[rr_ptr_i] = 1'b1;
            next_ptr_o      = other;
        end else if (elig_i[other]) begin
            win_o[other] = 1'b1;
            next_ptr_o   = rr_ptr_i;
        end
    end

endmodule

// File: rtl/fifo_access_ctrl.sv
// Schedules one FIFO operation per cycle (read, write 0 or write 1), tracks
// occupancy to block overflow/underflow, and runs a one-cycle flush sequence.
module fifo_access_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DEPTH_LOG2   = 10,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        wr_req,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic [DATA_W-1:0] wr_data1,
    output logic [1:0]        wr_ack,
    input  logic              rd_req,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    input  logic              flush,
    output logic [DEPTH_LOG2:0] occupancy,
    output logic              full,
    output logic              empty,
    output logic              fifo_we,
    output logic              fifo_re,
    output logic              fifo_clr,
    output logic [DATA_W-1:0] fifo_din,
    input  logic [DATA_W-1:0] fifo_dout
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [DEPTH_LOG2:0] DEPTH_V = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);
    localparam logic [SW-1:0]       LIMIT_V = SW'(STARVE_LIMIT);

    state_t              state_q;
    logic [DEPTH_LOG2:0] occ_q;
    logic [SW-1:0]       starve_q;
    logic                rr_q;

    logic       full_int, empty_int, rd_elig, any_wr, next_ptr, din_sel;
    logic [1:0] wr_elig, win;
    gnt_t       gnt;

    assign full_int  = (occ_q == DEPTH_V);
    assign empty_int = (occ_q == '0);
    assign rd_elig   = rd_req && !empty_int;
    assign wr_elig   = wr_req & {2{!full_int}};
    assign any_wr    = |wr_elig;

    fifo_wr_rr_arb u_arb (
        .elig_i     (wr_elig),
        .rr_ptr_i   (rr_q),
        .win_o      (win),
        .next_ptr_o (next_ptr)
    );

    // Reads win unless writers have been passed over STARVE_LIMIT times in a row.
    always_comb begin
        gnt = GNT_NONE;
        if (!reset && state_q == ST_RUN && !flush) begin
            if (rd_elig && (starve_q < LIMIT_V || !any_wr)) gnt = GNT_RD;
            else if (win == 2'b01)                          gnt = GNT_WR0;
            else if (win == 2'b10)                          gnt = GNT_WR1;
        end
    end

    assign rd_ack    = (gnt == GNT_RD);
    assign fifo_re   = rd_ack;
    assign wr_ack    = {gnt == GNT_WR1, gnt == GNT_WR0};
    assign fifo_we   = |wr_ack;
    assign din_sel   = (gnt == GNT_WR1) || (gnt != GNT_WR0 && rr_q);
    assign fifo_din  = din_sel ? wr_data1 : wr_data0;
    assign rd_data   = fifo_dout;
    assign fifo_clr  = reset || (state_q == ST_FLUSH);
    assign occupancy = reset ? '0 : occ_q;
    assign full      = !reset && full_int;
    assign empty     = reset || empty_int;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            occ_q    <= '0;
            starve_q <= '0;
            rr_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (flush) state_q <= ST_FLUSH;
                    if (fifo_re)      occ_q <= occ_q - 1'b1;
                    else if (fifo_we) occ_q <= occ_q + 1'b1;
                    if (fifo_we) rr_q <= next_ptr;
                    if (fifo_we || !any_wr)               starve_q <= '0;
                    else if (fifo_re && starve_q != '1)   starve_q <= starve_q + 1'b1;
                end
                ST_FLUSH: begin
                    state_q  <= ST_RUN;
                    occ_q    <= '0;
                    starve_q <= '0;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Bench for fifo_access_ctrl at depth 4, starve limit 2: directed scenarios
// plus random traffic, checked against a queue-based reference model.
module tb_fifo_access_ctrl;

    localparam int DL    = 2;
    localparam int DW    = 8;
    localparam int SL    = 2;
    localparam int DEPTH = 1 << DL;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    wr_req = 2'b00;
    logic [DW-1:0] wr_data0 = '0, wr_data1 = '0;
    logic [1:0]    wr_ack;
    logic          rd_req = 1'b0, rd_ack;
    logic [DW-1:0] rd_data;
    logic          flush = 1'b0;
    logic [DL:0]   occupancy;
    logic          full, empty, fifo_we, fifo_re, fifo_clr;
    logic [DW-1:0] fifo_din;
    logic [DW-1:0] fifo_dout = '0;

    always #5 clk = ~clk;

    fifo_access_ctrl #(.DEPTH_LOG2(DL), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset), .wr_req(wr_req), .wr_data0(wr_data0),
        .wr_data1(wr_data1), .wr_ack(wr_ack), .rd_req(rd_req), .rd_ack(rd_ack),
        .rd_data(rd_data), .flush(flush), .occupancy(occupancy), .full(full),
        .empty(empty), .fifo_we(fifo_we), .fifo_re(fifo_re), .fifo_clr(fifo_clr),
        .fifo_din(fifo_din), .fifo_dout(fifo_dout)
    );

    // Show-ahead buffer driven by the DUT's FIFO controls.
    logic [DW-1:0] buf_q[$];
    always @(posedge clk) begin
        if (fifo_clr) buf_q.delete();
        else if (fifo_we) buf_q.push_back(fifo_din);
        else if (fifo_re && buf_q.size() > 0) void'(buf_q.pop_front());
        fifo_dout <= (buf_q.size() > 0) ? buf_q[0] : '0;
    end

    // Reference model state.
    logic [DW-1:0] exp_q[$];
    int            m_starve = 0;
    bit            m_rr = 1'b0;
    bit            m_flushing = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [1:0]    obs_wr_ack;
    logic          obs_rd_ack, obs_clr;
    logic [DW-1:0] obs_din, obs_rdata;
    logic [DL:0]   obs_occ;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input logic [1:0] wq, input logic [DW-1:0] d0,
                        input logic [DW-1:0] d1, input bit rq, input bit fl);
        bit [1:0] e_wack, wr_ok;
        bit       e_rack, e_clr, rd_ok, chk_din, run;
        int       cnt, win;
        logic [DW-1:0] e_din;
        reset = rst; wr_req = wq; wr_data0 = d0; wr_data1 = d1; rd_req = rq; flush = fl;
        @(negedge clk);
        cnt = exp_q.size();
        e_wack = 2'b00; e_rack = 1'b0; chk_din = 1'b0; win = -1; e_din = '0;
        run = !rst && !m_flushing;
        e_clr = !run;
        rd_ok = rq && cnt > 0;
        wr_ok = wq & {2{cnt < DEPTH}};
        if (run && !fl) begin
            if (rd_ok && (m_starve < SL || wr_ok == 2'b00)) e_rack = 1'b1;
            else if (wr_ok != 2'b00) begin
                win = wr_ok[m_rr] ? int'(m_rr) : 1 - int'(m_rr);
                e_wack[win] = 1'b1;
            end
            chk_din = !e_rack;
            e_din = (((win >= 0) ? win : int'(m_rr)) == 1) ? d1 : d0;
        end
        check("wr_ack", wr_ack, e_wack);
        check("rd_ack", rd_ack, e_rack);
        check("fifo_we", fifo_we, |e_wack);
        check("fifo_re", fifo_re, e_rack);
        check("fifo_clr", fifo_clr, e_clr);
        check("occupancy", occupancy, rst ? 0 : cnt);
        check("full", full, !rst && cnt == DEPTH);
        check("empty", empty, rst || cnt == 0);
        if (chk_din) check("fifo_din", fifo_din, e_din);
        if (e_rack) check("rd_data", rd_data, exp_q[0]);
        obs_wr_ack = wr_ack; obs_rd_ack = rd_ack; obs_clr = fifo_clr;
        obs_din = fifo_din; obs_rdata = rd_data; obs_occ = occupancy;
        if (rst) begin
            exp_q.delete(); m_starve = 0; m_rr = 1'b0; m_flushing = 1'b0;
        end else if (m_flushing) begin
            exp_q.delete(); m_starve = 0; m_flushing = 1'b0;
        end else begin
            if (fl) m_flushing = 1'b1;
            if (e_rack) void'(exp_q.pop_front());
            if (win >= 0) begin
                exp_q.push_back(win == 1 ? d1 : d0);
                m_rr = (win == 0);
            end
            if (win >= 0 || wr_ok == 2'b00) m_starve = 0;
            else if (e_rack) m_starve++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 2'b00, '0, '0, 1'b0, 1'b0);
        step(1'b1, 2'b00, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 2'b01, DW'($urandom), DW'($urandom), 1'b0, 1'b0);
    endtask

    logic [1:0]    rr_exp[4]  = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [DW-1:0] din_exp[4] = '{8'hA0, 8'hB1, 8'hA0, 8'hB1};
    bit            starve_exp[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        // Reset outputs and round-robin fill to full.
        do_reset();
        check("rst_clr", obs_clr, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b11, 8'hA0, 8'hB1, 1'b0, 1'b0);
            check("rr_ack", obs_wr_ack, rr_exp[i]);
            check("rr_din", obs_din, din_exp[i]);
        end
        step(1'b0, 2'b11, 8'hA0, 8'hB1, 1'b0, 1'b0);
        check("rr_full_ack", obs_wr_ack, 2'b00);
        check("rr_full_occ", obs_occ, 3'd4);

        // Read on empty, then a single write becomes readable next cycle.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b00, '0, '0, 1'b1, 1'b0);
            check("empty_rd_ack", obs_rd_ack, 1'b0);
        end
        step(1'b0, 2'b01, 8'h5C, 8'h00, 1'b1, 1'b0);
        check("empty_wr_ack", obs_wr_ack, 2'b01);
        step(1'b0, 2'b00, '0, '0, 1'b1, 1'b0);
        check("empty_rd_then", obs_rd_ack, 1'b1);
        check("empty_rd_data", obs_rdata, 8'h5C);
        step(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
        check("empty_occ", obs_occ, 3'd0);

        // Starvation: reads win twice, then the writer gets a turn.
        do_reset();
        fill(3);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 2'b01, DW'($urandom), 8'h00, 1'b1, 1'b0);
            if (i < 6) check("starve_pat", obs_rd_ack, starve_exp[i]);
        end

        // Flush with everything requesting, flush held into ST_FLUSH once.
        do_reset();
        fill(3);
        step(1'b0, 2'b11, 8'h11, 8'h22, 1'b1, 1'b1);
        check("fl_c1_ack", {obs_wr_ack, obs_rd_ack}, 3'b000);
        step(1'b0, 2'b11, 8'h11, 8'h22, 1'b1, 1'b1);
        check("fl_c2_clr", obs_clr, 1'b1);
        check("fl_c2_ack", {obs_wr_ack, obs_rd_ack}, 3'b000);
        step(1'b0, 2'b11, 8'h11, 8'h22, 1'b1, 1'b0);
        check("fl_c3_occ", obs_occ, 3'd0);
        check("fl_c3_ack", obs_wr_ack, 2'b10);

        // Reset in the middle of a write.
        do_reset();
        fill(2);
        step(1'b1, 2'b01, 8'h77, 8'h00, 1'b0, 1'b0);
        check("rst_mid_clr", obs_clr, 1'b1);
        step(1'b0, 2'b11, 8'h77, 8'h88, 1'b0, 1'b0);
        check("rst_mid_occ", obs_occ, 3'd0);
        check("rst_mid_ack", obs_wr_ack, 2'b01);

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) == 0, 2'($urandom), DW'($urandom), DW'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_access_ctrl.md
# fifo_access_ctrl

Scheduler that shares one single-port-per-cycle 8-bit FIFO between two write requesters and one read consumer. The FIFO accepts at most one operation per clock, so this block picks one operation per cycle: read, write from requester 0, or write from requester 1. It tracks occupancy itself to prevent overflow and underflow, and provides a flush sequence. It sits between the producers (for example, RX front ends) and the buffer instance, and drives the buffer's read enable, write enable, data-in and clear.

## Interface
- DEPTH_LOG2, 10, log2 of FIFO depth; DEPTH = 1<<DEPTH_LOG2
- DATA_W, 8, data width
- STARVE_LIMIT, 4, consecutive lost write cycles after which writes outrank reads
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- wr_req  in  2  write request per requester; bit i = requester i
- wr_data0 / wr_data1  in  DATA_W  write data for each requester, valid while its wr_req is high
- wr_ack  out  2  one-hot write grant; data is consumed in the ack cycle
- rd_req  in  1  consumer requests a word
- rd_ack  out  1  read grant; rd_data is valid in the same cycle
- rd_data  out  DATA_W  equals fifo_dout (head word, show-ahead)
- flush  in  1  request to empty the FIFO
- occupancy  out  DEPTH_LOG2+1  words stored, range 0..DEPTH
- full / empty  out  1  occupancy==DEPTH / occupancy==0
- fifo_we / fifo_re / fifo_clr  out  1  FIFO controls
- fifo_din  out  DATA_W  FIFO write data
- fifo_dout  in  DATA_W  FIFO head word

## Operation
- **States:** ST_RUN and ST_FLUSH.
  - Reset enters ST_RUN with occupancy=0, rr_ptr=0 (requester 0 preferred), starve=0.
- **Eligibility (ST_RUN):**
  - rd_elig = rd_req && !empty.
  - wr_elig[i] = wr_req[i] && !full.
- **Grant priority (ST_RUN, flush=0):**
  1. If rd_elig and (starve<STARVE_LIMIT or no wr_elig): read. Drive fifo_re=1 and rd_ack=1.
  2. Otherwise, if any wr_elig: write. The winner is rr_ptr if it is eligible, else the other requester. Drive fifo_we=1, wr_ack[winner]=1, fifo_din=wr_data[winner], and set rr_ptr to the other requester (1-winner).
  3. Otherwise: idle. fifo_din = wr_data[rr_ptr].
- **Occupancy:** +1 on a write, -1 on a read. Reads and writes never occur in the same cycle. It cannot wrap because full blocks writes and empty blocks reads.
- **starve:** saturating counter, width $clog2(STARVE_LIMIT+1).
  - Increments when some wr_elig is high and the read wins.
  - Clears on any write grant, and on any cycle with no wr_elig.
- **flush=1 in ST_RUN:** no grants that cycle; next state is ST_FLUSH.
- **ST_FLUSH (exactly 1 cycle):**
  - fifo_clr=1, no acks.
  - occupancy←0, starve←0, rr_ptr held.
  - Next state is ST_RUN. A flush still high here is ignored, so re-flushing requires a new assertion in ST_RUN.
- **fifo_clr** = reset || state==ST_FLUSH.
- **Reset mid-operation:** returns to ST_RUN with all counters cleared; any in-flight request is simply un-acked.

## Timing
- All acks, fifo_re, fifo_we and fifo_din are combinational from registered state plus the current inputs. Grant latency is 0 cycles.
- Requesters hold req and data until ack. A req deasserted before ack is legal and withdraws the request.
- occupancy, full and empty update the cycle after the grant.
- Outputs while reset=1: all acks=0, fifo_re=0, fifo_we=0, fifo_clr=1, occupancy=0, empty=1, full=0.
- Flush costs 2 grant-free cycles: the flush-request cycle plus the ST_FLUSH cycle.
- **Boundary cases:**
  - At full, a read may still be granted. Writes resume the cycle after occupancy drops.
  - At empty, rd_req is never acked. A write granted this cycle makes the word readable next cycle.

## Structure
- Package fifo_ctrl_pkg holds:
  - state enum {ST_RUN, ST_FLUSH}
  - grant encoding constants GNT_NONE, GNT_RD, GNT_WR0, GNT_WR1
- Sub-module fifo_wr_rr_arb: 2-way round-robin arbiter.
  - Inputs: eligibility vector, rr_ptr.
  - Outputs: one-hot winner and next_ptr.
- The controller instantiates fifo_wr_rr_arb and owns the FSM, occupancy counter and starve counter.

## Test plan
All scenarios use DEPTH_LOG2=2 (depth 4) and STARVE_LIMIT=2.
- **Round-robin:** wr_req=2'b11 held for 4 cycles, with wr_data0=8'hA0, wr_data1=8'hB1 → wr_ack sequence 01,10,01,10; fifo_din A0,B1,A0,B1; occupancy 4; full=1; wr_ack=00 on cycle 5.
- **Read on empty:** rd_req=1 from reset with no writes → rd_ack stays 0. Then wr_req[0]=1 with data 8'h5C for 1 cycle → rd_ack=1 the following cycle with rd_data=8'h5C, and occupancy returns 0.
- **Starvation:** occupancy=3, rd_req=1 and wr_req=2'b01 held continuously → grants read, read, write (starve reached 2), read, read, write…; occupancy never exceeds 4 or goes below 0.
- **Flush:** occupancy=3, pulse flush for 1 cycle with wr_req=2'b11 and rd_req=1 → no acks for 2 cycles, fifo_clr=1 in the second, occupancy=0. Grants resume in cycle 3 starting with the requester at rr_ptr.
- **Reset mid-write:** reset asserted during a cycle with wr_ack=01 at occupancy=2 → next cycle occupancy=0, fifo_clr=1 while reset is high, and the first post-reset write grant goes to requester 0.
